wbufifo_ctl: RTL and testbench



---
 rtl/wbufifo_ctl_if.sv | 97 +++++++++
 rtl/wbufifo_ctl.sv | 203 ++++++++++++++++++++
 tb/tb_wbufifo_ctl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbufifo_ctl_if.sv
// -----------------------------------------------------------------------------
// wbufifo_ctl_if
// Bundles the requester, FIFO-side and output-stage signals of wbufifo_ctl.
// Signal names keep their i_/o_ prefixes as seen from the controller.
//
// Modports:
//   master : controller view (drives all o_* signals, samples all i_* signals)
//   slave  : environment view (requesters, FIFO and downstream sink)
//
// Signals:
//   i_req_stb[NREQ]      per-requester word valid
//   i_req_data[NREQ*BW]  requester words, requester k at [k*BW +: BW]
//   o_req_busy[NREQ]     per-requester stall
//   o_fifo_rst           synchronous reset to the FIFO
//   o_fifo_wr            FIFO write strobe
//   o_fifo_data[BW]      FIFO write data
//   i_fifo_empty_n       FIFO not-empty flag
//   i_fifo_data[BW]      FIFO head word
//   o_fifo_rd            FIFO read strobe
//   o_stb / o_data[BW]   output word valid / word
//   i_busy               downstream stall
//   o_fill[LGFLEN]       committed occupancy
//   o_err                sticky accounting error
//   i_hwm_clr, o_hwm     high-water mark clear / value (WBUFIFO_CTL_HWM_EN only)
//
// Parameters must match those of the wbufifo_ctl instance it is bound to.
// -----------------------------------------------------------------------------
interface wbufifo_ctl_if #(
  parameter int NREQ   = 2,
  parameter int BW     = 36,
  parameter int LGFLEN = 10
);

  logic [NREQ-1:0]    i_req_stb;
  logic [NREQ*BW-1:0] i_req_data;
  logic [NREQ-1:0]    o_req_busy;
  logic               o_fifo_rst;
  logic               o_fifo_wr;
  logic [BW-1:0]      o_fifo_data;
  logic               i_fifo_empty_n;
  logic [BW-1:0]      i_fifo_data;
  logic               o_fifo_rd;
  logic               o_stb;
  logic [BW-1:0]      o_data;
  logic               i_busy;
  logic [LGFLEN-1:0]  o_fill;
  logic               o_err;
`ifdef WBUFIFO_CTL_HWM_EN
  logic               i_hwm_clr;
  logic [LGFLEN-1:0]  o_hwm;
`endif

  modport master (
    input  i_req_stb,
    input  i_req_data,
    output o_req_busy,
    output o_fifo_rst,
    output o_fifo_wr,
    output o_fifo_data,
    input  i_fifo_empty_n,
    input  i_fifo_data,
    output o_fifo_rd,
    output o_stb,
    output o_data,
    input  i_busy,
    output o_fill,
    output o_err
`ifdef WBUFIFO_CTL_HWM_EN
    ,
    input  i_hwm_clr,
    output o_hwm
`endif
  );

  modport slave (
    output i_req_stb,
    output i_req_data,
    input  o_req_busy,
    input  o_fifo_rst,
    input  o_fifo_wr,
    input  o_fifo_data,
    output i_fifo_empty_n,
    output i_fifo_data,
    input  o_fifo_rd,
    input  o_stb,
    input  o_data,
    output i_busy,
    input  o_fill,
    input  o_err
`ifdef WBUFIFO_CTL_HWM_EN
    ,
    output i_hwm_clr,
    input  o_hwm
`endif
  );

endinterface

// File: rtl/wbufifo_ctl.sv
// -----------------------------------------------------------------------------
// wbufifo_ctl
// Shares the write port of one synchronous codeword FIFO among NREQ
// requesters with round-robin arbitration, tracks FIFO occupancy with a
// credit counter so the FIFO can never overflow, and drains the FIFO into a
// registered valid/busy output stage at up to one word per clock.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      wbufifo_ctl_if.master (requesters, FIFO control, output stage,
//            occupancy and error status)
//
// Optional feature (macro WBUFIFO_CTL_HWM_EN):
//   adds a registered high-water mark of o_fill on bus.o_hwm, reloaded from
//   o_fill by bus.i_hwm_clr.
// -----------------------------------------------------------------------------
module wbufifo_ctl #(
  parameter int NREQ   = 2,
  parameter int BW     = 36,
  parameter int LGFLEN = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  wbufifo_ctl_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Reset sequencer encodings
  localparam logic [0:0] S_RST = 1'b0;
  localparam logic [0:0] S_RUN = 1'b1;

  logic [0:0]        r_state;
  logic [PW-1:0]     r_ptr;
  logic              r_fifo_wr;
  logic [BW-1:0]     r_fifo_data;
  logic              r_stb;
  logic [BW-1:0]     r_data;
  logic [LGFLEN-1:0] r_fill;
  logic              r_err;

  logic              w_run;
  logic              w_any;
  logic              w_space;
  logic              w_accept;
  logic              w_rd;
  logic [NREQ-1:0]   w_rot;
  logic [PW:0]       w_off;
  logic [PW:0]       w_sum;
  logic [PW:0]       w_nsum;
  logic [PW-1:0]     w_grant;
  logic [PW-1:0]     w_gnext;
  logic [BW-1:0]     w_gdata;
  logic [NREQ-1:0]   w_busy;

  // ---------------------------------------------------------------------------
  // Reset sequencer: RST holds the FIFO in reset for one clock beyond the
  // release of i_rst_n, so the FIFO sees a clean synchronous reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RST;
    end else begin
      r_state <= S_RUN;
    end
  end

  assign w_run = (r_state == S_RUN);

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // ---------------------------------------------------------------------------
  assign w_any   = |bus.i_req_stb;
  assign w_space = (r_fill != '1);
  // Space comes from the registered counter only, so a read in this clock
  // frees a slot no earlier than the next clock (no rd -> busy path).
  assign w_accept = w_run && w_space && w_any;

  // Rotate the strobes so bit j is requester (r_ptr + j) mod NREQ, take the
  // lowest set bit, then rotate the offset back into a requester index.
  always_comb begin
    w_rot = NREQ'({bus.i_req_stb, bus.i_req_stb} >> r_ptr);
    w_off = '0;
    for (int unsigned j = NREQ; j > 0; j--) begin
      if (w_rot[j-1]) begin
        w_off = (PW+1)'(j - 1);
      end
    end
    w_sum = {1'b0, r_ptr} + w_off;
    if (w_sum >= (PW+1)'(NREQ)) begin
      w_sum = w_sum - (PW+1)'(NREQ);
    end
    w_grant = w_sum[PW-1:0];
    w_nsum  = w_sum + (PW+1)'(1);
    if (w_nsum >= (PW+1)'(NREQ)) begin
      w_nsum = '0;
    end
    w_gnext = w_nsum[PW-1:0];
  end

  always_comb begin
    w_gdata = '0;
    w_busy  = '1;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_grant == PW'(k)) begin
        w_gdata = bus.i_req_data[k*BW +: BW];
      end
      w_busy[k] = !(w_accept && (w_grant == PW'(k)));
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO write port (one-clock write latency) and arbitration pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
      r_ptr       <= '0;
    end else begin
      r_fifo_wr <= w_accept;
      if (w_accept) begin
        r_fifo_data <= w_gdata;
        r_ptr       <= w_gnext;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drain into the output stage
  // ---------------------------------------------------------------------------
  assign w_rd = w_run && bus.i_fifo_empty_n && (!r_stb || !bus.i_busy);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stb  <= 1'b0;
      r_data <= '0;
    end else if (w_rd) begin
      r_stb  <= 1'b1;
      r_data <= bus.i_fifo_data;
    end else if (!bus.i_busy) begin
      r_stb  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter: counts words accepted (including the one still in flight
  // to the FIFO) minus words read out. A read with no credit is a fault.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill <= '0;
      r_err  <= 1'b0;
    end else begin
      case ({w_accept, w_rd})
        2'b10: r_fill <= r_fill + LGFLEN'(1);
        2'b01: begin
          if (r_fill != '0) begin
            r_fill <= r_fill - LGFLEN'(1);
          end
        end
        default: ;
      endcase
      if (w_rd && (r_fill == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef WBUFIFO_CTL_HWM_EN
  // ---------------------------------------------------------------------------
  // High-water mark of the committed occupancy
  // ---------------------------------------------------------------------------
  logic [LGFLEN-1:0] r_hwm;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hwm <= '0;
    end else if (bus.i_hwm_clr) begin
      r_hwm <= r_fill;
    end else if (r_fill > r_hwm) begin
      r_hwm <= r_fill;
    end
  end

  assign bus.o_hwm = r_hwm;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_req_busy  = w_busy;
  assign bus.o_fifo_rst  = (r_state == S_RST);
  assign bus.o_fifo_wr   = r_fifo_wr;
  assign bus.o_fifo_data = r_fifo_data;
  assign bus.o_fifo_rd   = w_rd;
  assign bus.o_stb       = r_stb;
  assign bus.o_data      = r_data;
  assign bus.o_fill      = r_fill;
  assign bus.o_err       = r_err;

endmodule

// File: tb/tb_wbufifo_ctl.sv
// -----------------------------------------------------------------------------
// tb_wbufifo_ctl
// Directed bench for wbufifo_ctl with NREQ=2, BW=16, LGFLEN=3 (8-entry FIFO,
// 7 usable words). A small FIFO model stands in for the codeword FIFO.
// -----------------------------------------------------------------------------
module tb_wbufifo_ctl;

  localparam int NREQ   = 2;
  localparam int BW     = 16;
  localparam int LGFLEN = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [BW-1:0] d0, d1;
  logic force_ne;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  wbufifo_ctl_if #(.NREQ(NREQ), .BW(BW), .LGFLEN(LGFLEN)) bus ();

  wbufifo_ctl #(.NREQ(NREQ), .BW(BW), .LGFLEN(LGFLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  assign bus.i_req_data = {d1, d0};

  // FIFO model: 8 entries, head word driven from registered read pointer
  logic [BW-1:0] mem [0:7];
  logic [3:0]    wp  = '0;
  logic [3:0]    rp  = '0;
  logic          ovf = 1'b0;

  always_ff @(posedge clk) begin
    if (bus.o_fifo_rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (bus.o_fifo_wr) begin
        if (4'(wp - rp) >= 4'd7) ovf <= 1'b1;
        mem[wp[2:0]] <= bus.o_fifo_data;
        wp <= wp + 4'd1;
      end
      if (bus.o_fifo_rd && (wp != rp)) rp <= rp + 4'd1;
    end
  end

  assign bus.i_fifo_empty_n = (wp != rp) || force_ne;
  assign bus.i_fifo_data    = mem[rp[2:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int unsigned n_acc;
  int unsigned n_stale;
  logic        done;

  initial begin
    rst_n         = 1'b0;
    d0            = 16'hA000;
    d1            = 16'hB000;
    force_ne      = 1'b0;
    bus.i_req_stb = 2'b11;
    bus.i_busy    = 1'b0;
`ifdef WBUFIFO_CTL_HWM_EN
    bus.i_hwm_clr = 1'b0;
`endif

    // ---- reset state
    #2;
    check("rst_fifo_rst", 32'(bus.o_fifo_rst), 1);
    check("rst_busy",     32'(bus.o_req_busy), 2'b11);
    check("rst_fifo_wr",  32'(bus.o_fifo_wr), 0);
    check("rst_fifo_data",32'(bus.o_fifo_data), 0);
    check("rst_stb",      32'(bus.o_stb), 0);
    check("rst_data",     32'(bus.o_data), 0);
    check("rst_fill",     32'(bus.o_fill), 0);
    check("rst_err",      32'(bus.o_err), 0);
    check("rst_rd",       32'(bus.o_fifo_rd), 0);
`ifdef WBUFIFO_CTL_HWM_EN
    check("rst_hwm",      32'(bus.o_hwm), 0);
`endif
    #1 rst_n = 1'b1;
    #1;
    check("rel_fifo_rst", 32'(bus.o_fifo_rst), 1);
    check("rel_busy",     32'(bus.o_req_busy), 2'b11);

    // ---- both requesters streaming, alternate grants
    tick;  // E1: RUN
    check("run_fifo_rst", 32'(bus.o_fifo_rst), 0);
    check("run_busy0",    32'(bus.o_req_busy), 2'b10);
    check("run_fill0",    32'(bus.o_fill), 0);
    check("run_wr0",      32'(bus.o_fifo_wr), 0);
    tick;  // E2: accept A000
    check("alt_wr1",   32'(bus.o_fifo_wr), 1);
    check("alt_data1", 32'(bus.o_fifo_data), 16'hA000);
    check("alt_fill1", 32'(bus.o_fill), 1);
    check("alt_busy1", 32'(bus.o_req_busy), 2'b01);
    d0 = 16'hA001;
    tick;  // E3: accept B000
    check("alt_data2", 32'(bus.o_fifo_data), 16'hB000);
    check("alt_fill2", 32'(bus.o_fill), 2);
    check("alt_busy2", 32'(bus.o_req_busy), 2'b10);
    check("alt_rd2",   32'(bus.o_fifo_rd), 1);
    check("alt_stb2",  32'(bus.o_stb), 0);
    d1 = 16'hB001;
    tick;  // E4: accept A001, read A000
    check("alt_data3", 32'(bus.o_fifo_data), 16'hA001);
    check("alt_fill3", 32'(bus.o_fill), 2);
    check("alt_stb3",  32'(bus.o_stb), 1);
    check("alt_out3",  32'(bus.o_data), 16'hA000);
    check("alt_busy3", 32'(bus.o_req_busy), 2'b01);
    d0 = 16'hA002;
    tick;  // E5: accept B001, read B000
    check("alt_data4", 32'(bus.o_fifo_data), 16'hB001);
    check("alt_out4",  32'(bus.o_data), 16'hB000);
    check("alt_fill4", 32'(bus.o_fill), 2);
    bus.i_req_stb = 2'b00;
    tick;  // E6: read A001
    check("alt_wr5",   32'(bus.o_fifo_wr), 0);
    check("alt_out5",  32'(bus.o_data), 16'hA001);
    check("alt_fill5", 32'(bus.o_fill), 1);
    check("alt_busy5", 32'(bus.o_req_busy), 2'b11);
    tick;  // E7: read B001
    check("alt_out6",  32'(bus.o_data), 16'hB001);
    check("alt_stb6",  32'(bus.o_stb), 1);
    check("alt_fill6", 32'(bus.o_fill), 0);
    check("alt_rd6",   32'(bus.o_fifo_rd), 0);
    tick;  // E8
    check("alt_stb7",  32'(bus.o_stb), 0);

    // ---- only requester 1 with r_ptr=0: granted at once, pointer wraps to 0
    d1 = 16'hC000;
    bus.i_req_stb = 2'b10;
    #1;
    check("r1_busy",  32'(bus.o_req_busy), 2'b01);
    tick;  // E9
    check("r1_wr",    32'(bus.o_fifo_wr), 1);
    check("r1_data",  32'(bus.o_fifo_data), 16'hC000);
    check("r1_fill",  32'(bus.o_fill), 1);
    bus.i_req_stb = 2'b11;
    #1;
    check("r1_ptr0",  32'(bus.o_req_busy), 2'b10);
    bus.i_req_stb = 2'b00;
    tick;  // E10
    check("r1_wr2",   32'(bus.o_fifo_wr), 0);
    check("r1_rd",    32'(bus.o_fifo_rd), 1);
    tick;  // E11
    check("r1_out",   32'(bus.o_data), 16'hC000);
    check("r1_stb",   32'(bus.o_stb), 1);
    check("r1_fill2", 32'(bus.o_fill), 0);
    tick;  // E12
    check("r1_stb2",  32'(bus.o_stb), 0);

    // ---- fill to capacity with downstream stalled
    d0 = 16'hD00D;
    bus.i_busy    = 1'b1;
    bus.i_req_stb = 2'b01;
    #1;
    check("full_busy0", 32'(bus.o_req_busy), 2'b10);
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.i_req_stb[0] && !bus.o_req_busy[0]) n_acc++;
      tick;
    end
    check("full_accepts", n_acc, 8);
    check("full_fill",    32'(bus.o_fill), 7);
    check("full_busy",    32'(bus.o_req_busy), 2'b11);
    check("full_wr",      32'(bus.o_fifo_wr), 0);
    check("full_stb",     32'(bus.o_stb), 1);
    check("full_out",     32'(bus.o_data), 16'hD00D);
    check("full_rd",      32'(bus.o_fifo_rd), 0);
    check("full_model",   32'(4'(wp - rp)), 7);
    check("full_ovf",     32'(ovf), 0);
    d0 = 16'hE0E0;
    bus.i_busy = 1'b0;
    #1;
    check("resume_busy_same", 32'(bus.o_req_busy), 2'b11);
    check("resume_rd",        32'(bus.o_fifo_rd), 1);
    tick;
    check("resume_fill",  32'(bus.o_fill), 6);
    check("resume_busy",  32'(bus.o_req_busy), 2'b10);
    tick;
    check("resume_wr",    32'(bus.o_fifo_wr), 1);
    check("resume_data",  32'(bus.o_fifo_data), 16'hE0E0);
    check("resume_fill2", 32'(bus.o_fill), 6);
    bus.i_req_stb = 2'b00;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_fill == 0 && !bus.o_stb) begin
        done = 1'b1;
        break;
      end
      tick;
    end
    check("drain_done", 32'(done), 1);
    check("drain_last", 32'(bus.o_data), 16'hE0E0);
    check("drain_err",  32'(bus.o_err), 0);
    check("drain_ovf",  32'(ovf), 0);

    // ---- read with zero credit sets sticky error
    force_ne = 1'b1;
    #1;
    check("err_rd", 32'(bus.o_fifo_rd), 1);
    tick;
    force_ne = 1'b0;
    check("err_set",  32'(bus.o_err), 1);
    check("err_fill", 32'(bus.o_fill), 0);
    tick;
    tick;
    check("err_sticky", 32'(bus.o_err), 1);
    check("err_fill2",  32'(bus.o_fill), 0);
    check("err_stb",    32'(bus.o_stb), 0);

`ifdef WBUFIFO_CTL_HWM_EN
    // ---- high-water mark
    bus.i_hwm_clr = 1'b1;
    tick;
    bus.i_hwm_clr = 1'b0;
    check("hwm_clr0", 32'(bus.o_hwm), 0);
    d0 = 16'h6666;
    bus.i_busy    = 1'b1;
    bus.i_req_stb = 2'b01;
    for (int i = 0; i < 7; i++) tick;
    bus.i_req_stb = 2'b00;
    check("hwm_fill6", 32'(bus.o_fill), 6);
    tick;
    check("hwm_six", 32'(bus.o_hwm), 6);
    bus.i_busy = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.o_fill == 2) begin
        bus.i_busy = 1'b1;
        done = 1'b1;
        break;
      end
    end
    check("hwm_drain2", 32'(done), 1);
    tick;
    check("hwm_fill2", 32'(bus.o_fill), 2);
    check("hwm_keep6", 32'(bus.o_hwm), 6);
    bus.i_hwm_clr = 1'b1;
    tick;
    bus.i_hwm_clr = 1'b0;
    check("hwm_clr2", 32'(bus.o_hwm), 2);
    bus.i_busy = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_fill == 0 && !bus.o_stb) begin
        done = 1'b1;
        break;
      end
      tick;
    end
    check("hwm_drained", 32'(done), 1);
`endif

    // ---- reset asserted mid-transfer
    d0 = 16'h5A5A;
    bus.i_busy    = 1'b1;
    bus.i_req_stb = 2'b01;
    for (int i = 0; i < 6; i++) tick;
    bus.i_req_stb = 2'b00;
    check("mid_fill5", 32'(bus.o_fill), 5);
    check("mid_stb1",  32'(bus.o_stb), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_stb0",      32'(bus.o_stb), 0);
    check("mid_fill0",     32'(bus.o_fill), 0);
    check("mid_fifo_rst",  32'(bus.o_fifo_rst), 1);
    check("mid_busy",      32'(bus.o_req_busy), 2'b11);
    check("mid_wr",        32'(bus.o_fifo_wr), 0);
    check("mid_data",      32'(bus.o_data), 0);
    check("mid_fifo_data", 32'(bus.o_fifo_data), 0);
    check("mid_err",       32'(bus.o_err), 0);
    tick;
    rst_n      = 1'b1;
    bus.i_busy = 1'b0;
    #1;
    check("mid_rel_rst", 32'(bus.o_fifo_rst), 1);
    n_stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (bus.o_stb || bus.o_fifo_rd) n_stale++;
    end
    check("mid_stale",   n_stale, 0);
    check("mid_run_rst", 32'(bus.o_fifo_rst), 0);
    check("mid_fill_end", 32'(bus.o_fill), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
